// File: rtl/data_mem_unit_if.sv
// Request/response bus between the MEM stage and the data memory unit.
interface data_mem_unit_if;
    logic        mRD;
    logic        mWR;
    logic [31:0] DAddr;
    logic [31:0] DataIn;
    logic [31:0] DataOut;
    logic        Busy;
    logic        Done;
    logic        AddrErr;

    modport master (
        output mRD, mWR, DAddr, DataIn,
        input  DataOut, Busy, Done, AddrErr
    );

    modport slave (
        input  mRD, mWR, DAddr, DataIn,
        output DataOut, Busy, Done, AddrErr
    );
endinterface

// File: rtl/data_mem_unit.sv
// Multi-cycle, byte-addressed, big-endian word memory with request/done handshake.
// Busy/Done are registered one cycle behind the internal state, so a request that
// arrives while Done is showing is ignored and the back-to-back period is WAIT_CYCLES+3.
module data_mem_unit #(
    parameter int unsigned DEPTH_BYTES = 128,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input logic            CLK,
    input logic            Reset,
    data_mem_unit_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH_BYTES);
    localparam int unsigned WW = AW - 2;
    localparam int unsigned CW = 4;
    localparam logic [31:0]   LAST_WORD = 32'(DEPTH_BYTES - 4);
    localparam logic [CW-1:0] WAIT_LOAD = CW'(WAIT_CYCLES);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [WW-1:0] word_q;
    logic [31:0]   wdata_q;
    logic          wr_q;
    logic [31:0]   dout_q;
    logic          busy_q, done_q, err_q;
    logic [7:0]    mem [DEPTH_BYTES];

    logic          req_c, ok_c, latch_c, access_c, err_c, acc_wr_c;
    logic [WW-1:0] acc_word_c;
    logic [31:0]   acc_data_c;

    // Request qualification: exactly one op, word aligned, inside storage.
    assign req_c = bus.mRD | bus.mWR;
    assign ok_c  = (bus.mRD ^ bus.mWR) && (bus.DAddr[1:0] == 2'b00) && (bus.DAddr <= LAST_WORD);

    // Next-state, counter and access control.
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        latch_c    = 1'b0;
        access_c   = 1'b0;
        err_c      = 1'b0;
        acc_word_c = word_q;
        acc_wr_c   = wr_q;
        acc_data_c = wdata_q;
        case (state)
            ST_IDLE: begin
                if (!done_q && req_c) begin
                    if (ok_c) begin
                        latch_c = 1'b1;
                        cnt_nx  = WAIT_LOAD;
                        if (WAIT_CYCLES == 0) begin
                            access_c   = 1'b1;
                            acc_word_c = bus.DAddr[AW-1:2];
                            acc_wr_c   = bus.mWR;
                            acc_data_c = bus.DataIn;
                            state_nx   = ST_DONE;
                        end else begin
                            state_nx = ST_WAIT;
                        end
                    end else begin
                        err_c = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt <= CW'(1)) begin
                    access_c = 1'b1;
                    cnt_nx   = '0;
                    state_nx = ST_DONE;
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // State, latched request, storage and registered outputs.
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            word_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            dout_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            for (int unsigned i = 0; i < DEPTH_BYTES; i++) begin
                mem[AW'(i)] <= 8'h00;
            end
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            busy_q <= (state == ST_WAIT);
            done_q <= (state == ST_DONE);
            err_q  <= err_c;
            if (latch_c) begin
                word_q  <= bus.DAddr[AW-1:2];
                wdata_q <= bus.DataIn;
                wr_q    <= bus.mWR;
            end
            if (access_c) begin
                if (acc_wr_c) begin
                    mem[{acc_word_c, 2'd0}] <= acc_data_c[31:24];
                    mem[{acc_word_c, 2'd1}] <= acc_data_c[23:16];
                    mem[{acc_word_c, 2'd2}] <= acc_data_c[15:8];
                    mem[{acc_word_c, 2'd3}] <= acc_data_c[7:0];
                end else begin
                    dout_q <= {mem[{acc_word_c, 2'd0}], mem[{acc_word_c, 2'd1}],
                               mem[{acc_word_c, 2'd2}], mem[{acc_word_c, 2'd3}]};
                end
            end
        end
    end

    assign bus.DataOut = dout_q;
    assign bus.Busy    = busy_q;
    assign bus.Done    = done_q;
    assign bus.AddrErr = err_q;
endmodule

// File: tb/tb_data_mem_unit.sv
// Bench for data_mem_unit: a WAIT_CYCLES=2 unit and a WAIT_CYCLES=0 unit against a byte-array model.
module tb_data_mem_unit;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;

    logic [7:0]  m0 [128];
    logic [7:0]  m1 [128];
    logic [31:0] mdout [2];

    data_mem_unit_if bus0 ();
    data_mem_unit_if bus1 ();

    data_mem_unit #(.DEPTH_BYTES(128), .WAIT_CYCLES(2)) dut0 (.CLK(clk), .Reset(rst), .bus(bus0));
    data_mem_unit #(.DEPTH_BYTES(128), .WAIT_CYCLES(0)) dut1 (.CLK(clk), .Reset(rst), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int u, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] d);
        if (u == 0) begin
            bus0.mRD = rd; bus0.mWR = wr; bus0.DAddr = a; bus0.DataIn = d;
        end else begin
            bus1.mRD = rd; bus1.mWR = wr; bus1.DAddr = a; bus1.DataIn = d;
        end
    endtask

    function automatic logic [31:0] model_word(input int u, input int a);
        if (u == 0) return {m0[a], m0[a+1], m0[a+2], m0[a+3]};
        return {m1[a], m1[a+1], m1[a+2], m1[a+3]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 128; i++) begin
            m0[i] = 8'h00;
            m1[i] = 8'h00;
        end
        mdout[0] = '0;
        mdout[1] = '0;
    endtask

    task automatic check_outputs(input string tag, input int u, input logic busy,
                                 input logic done, input logic err);
        if (u == 0) begin
            chk({tag, ".busy0"}, 32'(bus0.Busy), 32'(busy));
            chk({tag, ".done0"}, 32'(bus0.Done), 32'(done));
            chk({tag, ".err0"},  32'(bus0.AddrErr), 32'(err));
        end else begin
            chk({tag, ".busy1"}, 32'(bus1.Busy), 32'(busy));
            chk({tag, ".done1"}, 32'(bus1.Done), 32'(done));
            chk({tag, ".err1"},  32'(bus1.AddrErr), 32'(err));
        end
    endtask

    // One request held for a single edge; checks per-cycle handshake and final DataOut.
    task automatic xact(input string tag, input int u, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] d);
        int   w;
        logic acc;
        w   = (u == 0) ? 2 : 0;
        acc = (rd ^ wr) && (a[1:0] == 2'b00) && (a <= 32'd124);
        drive(u, rd, wr, a, d);
        @(posedge clk);
        @(negedge clk);
        drive(u, 1'b0, 1'b0, 32'h0, 32'h0);
        if (acc && wr) begin
            for (int k = 0; k < 4; k++) begin
                if (u == 0) m0[int'(a) + k] = d[31 - 8*k -: 8];
                else        m1[int'(a) + k] = d[31 - 8*k -: 8];
            end
        end
        if (acc && rd) mdout[u] = model_word(u, int'(a));
        for (int e = 0; e <= w + 2; e++) begin
            if (e > 0) @(negedge clk);
            check_outputs(tag, u, acc && e >= 1 && e <= w, acc && e == w + 1, !acc && e == 0);
        end
        chk({tag, ".dout"}, (u == 0) ? bus0.DataOut : bus1.DataOut, mdout[u]);
    endtask

    initial begin
        int          u;
        int          op;
        int          sel;
        logic [31:0] a;
        logic [31:0] d;
        n_cmp  = 0;
        n_fail = 0;
        model_reset();
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);

        // Reset for two edges, then release.
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        check_outputs("reset", 0, 1'b0, 1'b0, 1'b0);
        check_outputs("reset", 1, 1'b0, 1'b0, 1'b0);
        chk("reset.dout0", bus0.DataOut, 32'h0);
        chk("reset.dout1", bus1.DataOut, 32'h0);
        xact("rd0", 0, 1'b1, 1'b0, 32'h00, 32'h0);

        // Write/read back and byte-level big-endian peek.
        xact("wr8", 0, 1'b0, 1'b1, 32'h08, 32'h12345678);
        xact("rd8", 0, 1'b1, 1'b0, 32'h08, 32'h0);
        chk("rd8.value", bus0.DataOut, 32'h12345678);
        chk("peek8",  32'(dut0.mem[8]),  32'(m0[8]));
        chk("peek11", 32'(dut0.mem[11]), 32'(m0[11]));

        // Rejected requests leave DataOut alone.
        xact("mis0a", 0, 1'b1, 1'b0, 32'h0A, 32'h0);
        xact("oor80", 0, 1'b1, 1'b0, 32'h80, 32'h0);
        xact("both",  0, 1'b1, 1'b1, 32'h08, 32'h0);
        xact("upper", 0, 1'b0, 1'b1, 32'h0001_0008, 32'h11111111);
        xact("last",  0, 1'b0, 1'b1, 32'h7C, 32'h0BADF00D);

        // Reset one cycle into WAIT aborts the write.
        drive(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
        @(posedge clk);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        check_outputs("abort", 0, 1'b0, 1'b0, 1'b0);
        chk("abort.dout", bus0.DataOut, 32'h0);
        repeat (3) @(negedge clk);
        xact("abort.rd", 0, 1'b1, 1'b0, 32'h10, 32'h0);

        // Held read request: Done every WAIT_CYCLES+3 cycles.
        xact("wr7c", 0, 1'b0, 1'b1, 32'h7C, 32'hCAFEF00D);
        drive(0, 1'b1, 1'b0, 32'h7C, 32'h0);
        mdout[0] = model_word(0, 124);
        for (int e = 0; e < 15; e++) begin
            @(posedge clk);
            @(negedge clk);
            check_outputs("hold", 0, (e % 5 == 1) || (e % 5 == 2), e % 5 == 3, 1'b0);
        end
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("hold.dout", bus0.DataOut, 32'hCAFEF00D);
        @(negedge clk);

        // Zero-wait unit.
        xact("z.wr4", 1, 1'b0, 1'b1, 32'h04, 32'hA5A5A5A5);
        xact("z.rd4", 1, 1'b1, 1'b0, 32'h04, 32'h0);
        chk("z.value", bus1.DataOut, 32'hA5A5A5A5);

        // Randomized traffic on both units.
        for (int n = 0; n < 40; n++) begin
            u   = int'($urandom_range(0, 1));
            op  = int'($urandom_range(0, 3));
            sel = int'($urandom_range(0, 9));
            d   = $urandom;
            a   = {25'(0), 5'($urandom_range(0, 31)), 2'b00};
            if (sel == 7) a[1:0] = 2'($urandom_range(1, 3));
            if (sel == 8) a = a + 32'd128;
            if (sel == 9) a[31:16] = 16'($urandom_range(1, 65535));
            xact("rand", u, op != 1, op == 1 || op == 2, a, d);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
